// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//
// Multiplexed driver for a multi-digit common-anode 7-segment display.
// Holds a frame of hex digits and decimal points, decodes the digit in the
// current slot to segments, and scans the digit enables round-robin.
// Each slot opens with a short dead time (all anodes off) to avoid ghosting.
// New frames are loaded into a shadow register and committed only when the
// scan wraps, so a frame is never torn.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   enable       0 blanks the display (the scan keeps running)
//   lz_suppress  1 blanks leading zero digits (digit 0 is never blanked)
//   load         one-cycle strobe capturing digits_in / dp_in
//   digits_in    hex digits, digit k in bits [4k+3:4k], digit 0 least significant
//   dp_in        decimal point per digit, 1 = lit
//   seg_out      [7]=dp, [6:0]=a,b,c,d,e,f,g (polarity set by SEG_ACTIVE_LOW)
//   an_out       digit enables, bit k drives digit k (polarity set by DIG_ACTIVE_LOW)
//   frame_done   one-cycle pulse after each scan wrap
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned REFRESH_DIV    = 50000,
    parameter int unsigned BLANK_CYCLES   = 500,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    lz_suppress,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [7:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    frame_done
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0]      BLANK_END = CNT_W'(BLANK_CYCLES);

    // XOR masks that turn active-high patterns into pin polarity; they are
    // also the "everything off" pin values.
    localparam logic [7:0]            SEG_OFF = {8{SEG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{DIG_ACTIVE_LOW}};

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    pending_q, pending_d;
    logic [4*NUM_DIGITS-1:0] shadow_digits_q, shadow_digits_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [4*NUM_DIGITS-1:0] disp_digits_q, disp_digits_d;
    logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
    logic                    frame_done_q, frame_done_d;
    logic [7:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;

    // -------------------------------------------------------------------------
    // Segment decode, active-high, bit 6 = a ... bit 0 = g
    // -------------------------------------------------------------------------
    function automatic logic [6:0] decode_hex(input logic [3:0] value);
        logic [6:0] segs;
        segs = 7'b0000000;
        unique case (value)
            4'h0: segs = 7'b1111110;
            4'h1: segs = 7'b0110000;
            4'h2: segs = 7'b1101101;
            4'h3: segs = 7'b1111001;
            4'h4: segs = 7'b0110011;
            4'h5: segs = 7'b1011011;
            4'h6: segs = 7'b1011111;
            4'h7: segs = 7'b1110000;
            4'h8: segs = 7'b1111111;
            4'h9: segs = 7'b1111011;
            4'hA: segs = 7'b1110111;
            4'hB: segs = 7'b0011111;
            4'hC: segs = 7'b1001110;
            4'hD: segs = 7'b0111101;
            4'hE: segs = 7'b1001111;
            4'hF: segs = 7'b1000111;
        endcase
        return segs;
    endfunction

    // -------------------------------------------------------------------------
    // Scan timing
    // -------------------------------------------------------------------------
    logic slot_end;
    logic scan_wrap;

    always_comb begin
        slot_end  = (cnt_q == CNT_LAST);
        scan_wrap = slot_end && (idx_q == IDX_LAST);

        cnt_d = slot_end ? '0 : cnt_q + CNT_W'(1);

        idx_d = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end

        frame_done_d = scan_wrap;
    end

    // -------------------------------------------------------------------------
    // Frame load / commit
    // -------------------------------------------------------------------------
    always_comb begin
        shadow_digits_d = shadow_digits_q;
        shadow_dp_d     = shadow_dp_q;
        pending_d       = pending_q;
        disp_digits_d   = disp_digits_q;
        disp_dp_d       = disp_dp_q;

        if (load) begin
            shadow_digits_d = digits_in;
            shadow_dp_d     = dp_in;
        end

        if (scan_wrap) begin
            // A load landing on the wrap cycle bypasses the shadow so it is not
            // held back a whole frame; otherwise a pending frame is committed.
            if (load) begin
                disp_digits_d = digits_in;
                disp_dp_d     = dp_in;
            end else if (pending_q) begin
                disp_digits_d = shadow_digits_q;
                disp_dp_d     = shadow_dp_q;
            end
            pending_d = 1'b0;
        end else if (load) begin
            pending_d = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Leading-zero detection: zero_above[k] is set when display digits
    // k..NUM_DIGITS-1 are all zero.
    // -------------------------------------------------------------------------
    logic [NUM_DIGITS-1:0] zero_above;
    logic                  zero_run;

    always_comb begin
        zero_above = '0;
        zero_run   = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run      = zero_run && (disp_digits_q[4*k +: 4] == 4'h0);
            zero_above[k] = zero_run;
        end
    end

    // -------------------------------------------------------------------------
    // Current-slot selection
    // -------------------------------------------------------------------------
    logic [3:0]            cur_digit;
    logic                  cur_dp;
    logic                  cur_zero_above;
    logic [NUM_DIGITS-1:0] an_sel;

    always_comb begin
        cur_digit      = 4'h0;
        cur_dp         = 1'b0;
        cur_zero_above = 1'b0;
        an_sel         = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_digit      = disp_digits_q[4*k +: 4];
                cur_dp         = disp_dp_q[k];
                cur_zero_above = zero_above[k];
                an_sel[k]      = 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registered outputs, computed from the current (idx, cnt) state
    // -------------------------------------------------------------------------
    logic       digit_blank;
    logic [6:0] cur_segs;

    always_comb begin
        // Digit 0 is never a leading zero, so it is excluded explicitly.
        digit_blank = lz_suppress && (idx_q != '0) && cur_zero_above;
        cur_segs    = digit_blank ? 7'b0000000 : decode_hex(cur_digit);

        seg_d = SEG_OFF;
        an_d  = AN_OFF;
        if (enable) begin
            seg_d = {cur_dp, cur_segs} ^ SEG_OFF;
            // Dead time at the start of each slot keeps the previous digit's
            // segments from ghosting onto the next anode.
            if (cnt_q >= BLANK_END) begin
                an_d = an_sel ^ AN_OFF;
            end
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q           <= '0;
            idx_q           <= '0;
            pending_q       <= 1'b0;
            shadow_digits_q <= '0;
            shadow_dp_q     <= '0;
            disp_digits_q   <= '0;
            disp_dp_q       <= '0;
            frame_done_q    <= 1'b0;
            seg_q           <= SEG_OFF;
            an_q            <= AN_OFF;
        end else begin
            cnt_q           <= cnt_d;
            idx_q           <= idx_d;
            pending_q       <= pending_d;
            shadow_digits_q <= shadow_digits_d;
            shadow_dp_q     <= shadow_dp_d;
            disp_digits_q   <= disp_digits_d;
            disp_dp_q       <= disp_dp_d;
            frame_done_q    <= frame_done_d;
            seg_q           <= seg_d;
            an_q            <= an_d;
        end
    end

    assign seg_out    = seg_q;
    assign an_out     = an_q;
    assign frame_done = frame_done_q;

endmodule
